// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//
// Bundles the two buses that the boot loader sits between:
//   * the inbound byte stream (valid/ready handshake)
//       in_data    [7:0]         byte payload
//       in_valid                 in_data is valid this cycle
//       in_ready                 the loader can accept a byte
//   * the outbound instruction-memory write port
//       imem_we                  one-cycle write strobe
//       imem_addr  [ADDR_W-1:0]  write address
//       imem_wdata [DATA_W-1:0]  write data
//
// Modports:
//   slave  - the loader: it consumes the byte stream and drives the memory
//            write port.
//   master - the environment: it produces the byte stream and observes
//            (or forwards to the memory) the write port.
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Receives a boot image as a byte stream and writes it into the core's
// instruction memory, then releases the core.
//
// Frame: N (word count, 1..2**ADDR_W), then N words sent high byte first.
// When the macro IMEM_LOADER_CHECKSUM_EN is defined, one trailing byte
// follows that must equal the 8-bit sum of all 2N data bytes (N excluded);
// a mismatch ends the load in ERR.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   bus           imem_boot_loader_if.slave: byte stream in, imem write out
//   restart       one-cycle pulse; aborts a load or leaves DONE/ERR for IDLE
//   words_loaded  words written during the current load
//   busy          a load is in progress (HI, LO or CHK)
//   core_run      image complete; the core reset is driven from ~core_run
//   err           load failed (bad word count or checksum mismatch)
//
// DATA_W is fixed at 16 (two bytes per word); other values are unsupported.
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_boot_loader_if.slave    bus,
    input  logic                 restart,
    output logic [ADDR_W:0]      words_loaded,
    output logic                 busy,
    output logic                 core_run,
    output logic                 err
);

    localparam int CNT_W   = ADDR_W + 1;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int N_BYTES = DATA_W / 8;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_DONE,
        S_ERR
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;            // word count of this frame
    logic [ADDR_W-1:0]   addr_q, addr_d;      // next write address
    logic [CNT_W-1:0]    wl_q, wl_d;          // words written so far
    logic [7:0]          hi_q, hi_d;          // pending high byte
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                run_q, run_d;
    logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;        // running sum of data bytes
`endif

    logic                ready_state;
    logic                accept;
    logic                n_ok;
    logic                last_word;
    logic [DATA_W-1:0]   word_next;

    // Word assembly: the top byte lane comes from the held high byte, the
    // lower lane from the byte arriving now.
    generate
        for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lane
            if (gi == N_BYTES - 1) begin : g_hi
                assign word_next[gi*8 +: 8] = hi_q;
            end else begin : g_lo
                assign word_next[gi*8 +: 8] = bus.in_data;
            end
        end
    endgenerate

    // in_ready depends on state and restart only, never on in_valid, so the
    // upstream source sees no combinational loop. restart blocks the byte
    // in its cycle so that an abort can never write a half-assembled word.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign ready_state = (state_q == S_IDLE) || (state_q == S_HI) ||
                         (state_q == S_LO)   || (state_q == S_CHK);
    assign busy        = (state_q == S_HI) || (state_q == S_LO) ||
                         (state_q == S_CHK);
`else
    assign ready_state = (state_q == S_IDLE) || (state_q == S_HI) ||
                         (state_q == S_LO);
    assign busy        = (state_q == S_HI) || (state_q == S_LO);
`endif

    assign bus.in_ready = ready_state && !restart;
    assign accept       = bus.in_valid && bus.in_ready;

    // The count is checked in full integer width so that counts above the
    // memory depth can never alias onto a legal value.
    assign n_ok      = (bus.in_data != 8'h00) && (int'(bus.in_data) <= DEPTH);
    assign last_word = ((wl_q + CNT_ONE) == n_q);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wl_d    = wl_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        run_d   = run_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        if (restart) begin
            // Abort or leave a terminal state; any partial word is dropped.
            state_d = S_IDLE;
            wl_d    = '0;
            hi_d    = '0;
            run_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (n_ok) begin
                            n_d     = CNT_W'(bus.in_data);
                            addr_d  = '0;
                            wl_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum_d   = '0;
`endif
                            state_d = S_HI;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end
                    end
                end

                S_HI: begin
                    if (accept) begin
                        hi_d    = bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + bus.in_data;
`endif
                        state_d = S_LO;
                    end
                end

                S_LO: begin
                    if (accept) begin
                        // The write is registered, so it lands one cycle
                        // after this handshake while the next byte can
                        // already be accepted; input never stalls.
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = word_next;
                        addr_d  = addr_q + ADDR_ONE;
                        wl_d    = wl_q + CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + bus.in_data;
                        state_d = last_word ? S_CHK : S_HI;
`else
                        state_d = last_word ? S_DONE : S_HI;
`endif
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        if (bus.in_data == sum_q) begin
                            state_d = S_DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end
                    end
                end
`endif

                S_DONE: begin
                    // Registered from the state, so core_run first rises
                    // the cycle after the final write strobe.
                    run_d = 1'b1;
                end

                S_ERR: begin
                    err_d = 1'b1;
                    run_d = 1'b0;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            addr_q  <= '0;
            wl_q    <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wl_q    <= wl_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            run_q   <= run_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign words_loaded   = wl_q;
    assign core_run       = run_q;
    assign err            = err_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the processor core and its 32-entry, 16-bit instruction memory.
- Accepts a byte stream over a valid/ready handshake, from a UART receiver or a testbench.
- Packs the bytes into 16-bit instruction words and writes them into instruction memory at consecutive addresses starting at 0.
- When the image is complete, raises core_run to release the core from reset. This replaces the simulation-only file preload.

Parameters:
- ADDR_W, 5, instruction memory address width; depth is 2**ADDR_W words.
- DATA_W, 16, instruction word width; fixed at 2 bytes, and other values are unsupported.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
- in_data  in  8  byte stream payload.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid and in_ready are both 1 at a rising edge.
- restart  in  1  single-cycle pulse; returns the block from DONE or ERR to IDLE.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  instruction memory write address.
- imem_wdata  out  DATA_W  instruction memory write data.
- words_loaded  out  ADDR_W+1  count of words written in the current load.
- busy  out  1  a load is in progress (any state except IDLE, DONE, ERR).
- core_run  out  1  processor may run; the top level drives core reset from ~core_run.
- err  out  1  load failed.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE.
  - All outputs 0, except in_ready=1.
  - Internal count, address, high-byte and sum registers cleared.
- Frame format: byte0 = N (number of words), then N word pairs, high byte first then low byte. With the optional feature enabled, one checksum byte follows.
- FSM, all transitions on an accepted byte unless noted:
  - IDLE: accept N.
    - If N==0 or N>2**ADDR_W, go to ERR.
    - Otherwise latch N, clear addr and words_loaded, go to HI.
  - HI: latch the byte as word[15:8], go to LO.
  - LO: form {hi, byte}.
    - Next cycle: imem_we=1 for exactly one cycle, with imem_addr = current addr and imem_wdata = the word.
    - addr and words_loaded increment in that same cycle.
    - If words_loaded+1==N, go to DONE (or to CHK if the feature is enabled). Otherwise go to HI.
  - DONE: in_ready=0, core_run=1 (registered, first high the cycle after the last imem_we). Held until restart or reset.
  - ERR: in_ready=0, err=1, core_run=0. Held until restart or reset.
- in_ready:
  - 1 in IDLE, HI, LO (and CHK); 0 in DONE and ERR.
  - Combinational from state only. It does not depend on in_valid.
- Write latency: the imem_we pulse occurs 1 cycle after the LO byte handshake. Back-to-back bytes at full rate are supported; a write never stalls input.
- restart:
  - In DONE or ERR: go to IDLE next cycle, with core_run=0, err=0, words_loaded=0.
  - In IDLE/HI/LO/CHK: abort the load, go to IDLE, drop any partial word, and do not issue imem_we. A byte presented in the same cycle is not accepted; in_ready is forced to 0 in that cycle.
- Address wrap: impossible by construction because N≤depth. The addr register still wraps modulo 2**ADDR_W.
- Gaps in in_valid hold state indefinitely; there is no timeout.
- Async reset mid-load: immediate return to IDLE, with imem_we deasserted asynchronously. Memory contents already written are not cleared.
- core_run never asserts without a complete frame.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last LO byte, go to CHK.
  - The next accepted byte is compared with the 8-bit sum modulo 256 of all 2N data bytes; N is excluded.
  - Match: go to DONE. Mismatch: go to ERR. Words are already written in either case.
  - The sum register clears on IDLE→HI.
- Disabled: no CHK state and no sum register. The last LO byte goes directly to DONE.

Test Plan:
- Basic load: reset low 3 cycles, then stream 0x02, 0x10,0x4A, 0xD2,0x05 with valid held high → imem_we pulses twice:
  - addr 0 with data 0x104A;
  - addr 1 with data 0xD205.
  - Then words_loaded=2, core_run=1 one cycle after the second write, and in_ready=0.
- Invalid count: N=0x00 → err=1 next cycle and no imem_we. Separately, N=0x21 (33) → err=1. restart → IDLE, err=0, in_ready=1.
- Full depth with bubbles: N=32, valid toggled 1/0 → 32 writes to addresses 0..31 in order, and words_loaded=32 at DONE.
- Abort: send 0x03, 0xAA,0xBB, 0xCC (mid-word), then restart → exactly one write (addr 0, data 0xAABB), state IDLE. A new frame then loads from addr 0.
- Async reset: reset pulled low between the HI and LO bytes, asynchronously to clk → outputs clear immediately with no imem_we, and a subsequent frame loads correctly.
- Checksum (macro defined):
  - Frame 0x01, 0x12,0x34, then 0x46 → DONE, core_run=1.
  - Same frame with 0x47 → ERR, err=1, core_run=0, and one write to addr 0 with data 0x1234 still observed.
